// File: rtl/pe_channel_accum_if.sv
// Window-beat and result bundle between the line-buffer logic and the convolution PE.
// The master drives window beats; the slave (the PE) returns accumulated results.
interface pe_channel_accum_if #(
    parameter int PIC_BITS    = 2,
    parameter int WEIGHT_BITS = 3,
    parameter int KERNEL_SIZE = 5,
    parameter int RESULT_BITS = 16
);
    localparam int N = KERNEL_SIZE * KERNEL_SIZE;

    logic                   in_valid;
    logic [PIC_BITS-1:0]    pic    [N];
    logic [WEIGHT_BITS-1:0] weight [N];
    logic [RESULT_BITS-1:0] bias;
    logic [RESULT_BITS-1:0] result;
    logic                   result_valid;
    logic                   sat_flag;

    modport master (
        output in_valid, pic, weight, bias,
        input  result, result_valid, sat_flag
    );

    modport slave (
        input  in_valid, pic, weight, bias,
        output result, result_valid, sat_flag
    );
endinterface

// File: rtl/pe_channel_accum.sv
// Integer convolution PE: KxK multiply, registered adder tree, accumulation over CHANNELS
// beats with bias, then optional ReLU and saturation/truncation to RESULT_BITS.
module pe_channel_accum #(
    parameter int PIC_BITS    = 2,
    parameter int WEIGHT_BITS = 3,
    parameter int KERNEL_SIZE = 5,
    parameter int CHANNELS    = 3,
    parameter int RESULT_BITS = 16,
    parameter bit SIGNED      = 1'b0,
    parameter bit RELU        = 1'b0,
    parameter bit SATURATE    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    pe_channel_accum_if.slave bus
);
    localparam int N           = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PROD        = PIC_BITS + WEIGHT_BITS;
    localparam int TREE_STAGES = $clog2(N);
    localparam int ACC         = PROD + $clog2(N * CHANNELS) + 1;
    // Accumulator holds the bias at full range (plus a sign bit when unsigned) and one carry.
    localparam int AW          = ((ACC > RESULT_BITS + 1) ? ACC : RESULT_BITS + 1) + 1;
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic signed [AW-1:0] SAT_MAX = SIGNED ? AW'({(RESULT_BITS-1){1'b1}})
                                                      : AW'({RESULT_BITS{1'b1}});
    localparam logic signed [AW-1:0] SAT_MIN = SIGNED ? ~SAT_MAX : '0;

    function automatic logic signed [ACC-1:0] ext_pic(input logic [PIC_BITS-1:0] v);
        if (SIGNED) return ACC'(signed'(v));
        return ACC'(v);
    endfunction

    function automatic logic signed [ACC-1:0] ext_wt(input logic [WEIGHT_BITS-1:0] v);
        if (SIGNED) return ACC'(signed'(v));
        return ACC'(v);
    endfunction

    function automatic logic signed [AW-1:0] ext_bias(input logic [RESULT_BITS-1:0] v);
        if (SIGNED) return AW'(signed'(v));
        return AW'(v);
    endfunction

    logic [CW-1:0]          chan_cnt_q, chan_cnt_d;
    logic                   first_d, last_d;
    logic [TREE_STAGES:0]   vld_q, fst_q, lst_q;
    logic [RESULT_BITS-1:0] bias_q [TREE_STAGES+1];
    logic signed [ACC-1:0]  lvl_d  [TREE_STAGES+1][N];
    logic signed [ACC-1:0]  lvl_q  [TREE_STAGES+1][N];
    logic signed [AW-1:0]   acc_q, acc_d;
    logic                   acc_done_q;
    logic signed [AW-1:0]   relu_d;
    logic [RESULT_BITS-1:0] result_d, result_q;
    logic                   sat_d, sat_flag_q, result_valid_q;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        first_d    = (chan_cnt_q == '0);
        last_d     = (chan_cnt_q == CW'(CHANNELS - 1));
        chan_cnt_d = last_d ? '0 : chan_cnt_q + 1'b1;
    end

    // Level 0 holds products; each later level sums pairs, zero-padded slots make the odd one pass.
    always_comb begin
        for (int l = 0; l <= TREE_STAGES; l++) begin
            for (int i = 0; i < N; i++) lvl_d[l][i] = '0;
        end
        for (int i = 0; i < N; i++) lvl_d[0][i] = ext_pic(bus.pic[i]) * ext_wt(bus.weight[i]);
        for (int l = 1; l <= TREE_STAGES; l++) begin
            for (int i = 0; i < N; i++) begin
                if (2 * i + 1 < N)  lvl_d[l][i] = lvl_q[l-1][2*i] + lvl_q[l-1][2*i+1];
                else if (2 * i < N) lvl_d[l][i] = lvl_q[l-1][2*i];
            end
        end
    end

    // NOTE: datapath registers carry no reset; only the valid/first/last tags and the accumulator
    // decide what is observable, so clearing wide data arrays would cost routing for nothing.
    always_ff @(posedge clk) begin
        lvl_q     <= lvl_d;
        bias_q[0] <= bus.bias;
        for (int s = 1; s <= TREE_STAGES; s++) bias_q[s] <= bias_q[s-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            chan_cnt_q <= '0;
            vld_q      <= '0;
            fst_q      <= '0;
            lst_q      <= '0;
        end else begin
            vld_q[0] <= bus.in_valid;
            fst_q[0] <= first_d;
            lst_q[0] <= last_d;
            for (int s = 1; s <= TREE_STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
                fst_q[s] <= fst_q[s-1];
                lst_q[s] <= lst_q[s-1];
            end
            if (bus.in_valid) chan_cnt_q <= chan_cnt_d;
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (vld_q[TREE_STAGES]) begin
            acc_d = (fst_q[TREE_STAGES] ? ext_bias(bias_q[TREE_STAGES]) : acc_q)
                  + AW'(lvl_q[TREE_STAGES][0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc_q      <= '0;
            acc_done_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            acc_done_q <= vld_q[TREE_STAGES] & lst_q[TREE_STAGES];
        end
    end

    // ReLU is applied before the clamp, so zeroing a negative sum never raises sat_flag.
    always_comb begin
        relu_d = acc_q;
        if (RELU && acc_q[AW-1]) relu_d = '0;
        result_d = relu_d[RESULT_BITS-1:0];
        sat_d    = 1'b0;
        if (SATURATE && (relu_d > SAT_MAX)) begin
            result_d = SAT_MAX[RESULT_BITS-1:0];
            sat_d    = 1'b1;
        end else if (SATURATE && (relu_d < SAT_MIN)) begin
            result_d = SAT_MIN[RESULT_BITS-1:0];
            sat_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            sat_flag_q     <= 1'b0;
        end else begin
            result_valid_q <= acc_done_q;
            sat_flag_q     <= acc_done_q & sat_d;
            if (acc_done_q) result_q <= result_d;
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.sat_flag     = sat_flag_q;
endmodule

// File: tb/tb_pe_channel_accum.sv
// Five PE configurations share one directed stimulus stream; a window-level arithmetic model
// predicts every pulse, and literal expectations pin the model on the key scenarios.
module tb_pe_channel_accum;
    localparam int N   = 25;
    localparam int CH  = 3;
    localparam int LAT = 8;
    localparam int ND  = 5;
    localparam int PB  = 2;
    localparam int WB  = 3;

    localparam int RB [ND] = '{16, 16, 16, 8, 8};
    localparam int SG [ND] = '{0, 1, 1, 0, 0};
    localparam int RL [ND] = '{0, 0, 1, 0, 0};
    localparam int ST [ND] = '{1, 1, 1, 1, 0};

    typedef struct packed {
        logic [ND-1:0][31:0] res;
        logic [ND-1:0]       sat;
        logic [31:0]         cyc;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;  // asserted high despite the name
    always #5 clk = ~clk;

    pe_channel_accum_if #(.RESULT_BITS(16)) if0 ();
    pe_channel_accum_if #(.RESULT_BITS(16)) if1 ();
    pe_channel_accum_if #(.RESULT_BITS(16)) if2 ();
    pe_channel_accum_if #(.RESULT_BITS(8))  if3 ();
    pe_channel_accum_if #(.RESULT_BITS(8))  if4 ();

    pe_channel_accum u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    pe_channel_accum #(.SIGNED(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    pe_channel_accum #(.SIGNED(1'b1), .RELU(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    pe_channel_accum #(.RESULT_BITS(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    pe_channel_accum #(.RESULT_BITS(8), .SATURATE(1'b0)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;
    bit     chk_en = 1'b0;
    int     pic_v [N];
    int     wt_v  [N];
    longint acc_m [ND];
    int     mcnt = 0;
    longint held  [ND];
    ev_t    exp_q [$];
    ev_t    log_q [$];
    logic [31:0] ar [ND];
    logic        av [ND];
    logic        as [ND];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int bits, input int sg);
        longint m;
        m = v & ((64'sd1 <<< bits) - 1);
        if (sg != 0 && m >= (64'sd1 <<< (bits - 1))) m = m - (64'sd1 <<< bits);
        return m;
    endfunction

    function automatic void finalize(input longint acc, input int d, output longint res,
                                     output bit sat);
        longint v, hi, lo;
        v   = acc;
        sat = 1'b0;
        if (RL[d] != 0 && v < 0) v = 0;
        if (SG[d] != 0) begin
            hi = (64'sd1 <<< (RB[d] - 1)) - 1;
            lo = -(64'sd1 <<< (RB[d] - 1));
        end else begin
            hi = (64'sd1 <<< RB[d]) - 1;
            lo = 0;
        end
        if (ST[d] != 0 && v > hi) begin
            v = hi;  sat = 1'b1;
        end else if (ST[d] != 0 && v < lo) begin
            v = lo;  sat = 1'b1;
        end
        res = v & ((64'sd1 <<< RB[d]) - 1);
    endfunction

    // One accepted beat: add the window dot product; on the last channel queue the final value.
    task automatic model_beat(input int b);
        ev_t    e;
        bit     first, last, st;
        longint s, r;
        first = (mcnt == 0);
        last  = (mcnt == CH - 1);
        e     = '0;
        for (int d = 0; d < ND; d++) begin
            s = 0;
            for (int i = 0; i < N; i++) s += sx(pic_v[i], PB, SG[d]) * sx(wt_v[i], WB, SG[d]);
            acc_m[d] = (first ? sx(b, RB[d], SG[d]) : acc_m[d]) + s;
            finalize(acc_m[d], d, r, st);
            e.res[d] = 32'(r);
            e.sat[d] = st;
        end
        e.cyc = 32'(cyc + LAT);
        if (last) exp_q.push_back(e);
        mcnt = last ? 0 : mcnt + 1;
    endtask

    task automatic fill(input int p, input int w);
        for (int i = 0; i < N; i++) begin
            pic_v[i] = p;
            wt_v[i]  = w;
        end
    endtask

    task automatic drive(input bit v, input int b);
        for (int i = 0; i < N; i++) begin
            if0.pic[i] = 2'(pic_v[i]);  if0.weight[i] = 3'(wt_v[i]);
            if1.pic[i] = 2'(pic_v[i]);  if1.weight[i] = 3'(wt_v[i]);
            if2.pic[i] = 2'(pic_v[i]);  if2.weight[i] = 3'(wt_v[i]);
            if3.pic[i] = 2'(pic_v[i]);  if3.weight[i] = 3'(wt_v[i]);
            if4.pic[i] = 2'(pic_v[i]);  if4.weight[i] = 3'(wt_v[i]);
        end
        if0.in_valid = v;  if0.bias = 16'(b);
        if1.in_valid = v;  if1.bias = 16'(b);
        if2.in_valid = v;  if2.bias = 16'(b);
        if3.in_valid = v;  if3.bias = 8'(b);
        if4.in_valid = v;  if4.bias = 8'(b);
        if (rst_n) begin
            mcnt = 0;
            for (int d = 0; d < ND; d++) acc_m[d] = 0;
        end else if (v) begin
            model_beat(b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0);
    endtask

    // Cycle-by-cycle comparison of all five DUTs against the model queue.
    always @(negedge clk) begin
        bit pulse;
        ev_t e;
        ar[0] = 32'(if0.result);  av[0] = if0.result_valid;  as[0] = if0.sat_flag;
        ar[1] = 32'(if1.result);  av[1] = if1.result_valid;  as[1] = if1.sat_flag;
        ar[2] = 32'(if2.result);  av[2] = if2.result_valid;  as[2] = if2.sat_flag;
        ar[3] = 32'(if3.result);  av[3] = if3.result_valid;  as[3] = if3.sat_flag;
        ar[4] = 32'(if4.result);  av[4] = if4.result_valid;  as[4] = if4.sat_flag;
        if (chk_en) begin
            pulse = (exp_q.size() > 0) && (exp_q[0].cyc == 32'(cyc));
            for (int d = 0; d < ND; d++) begin
                check($sformatf("d%0d_valid@%0d", d, cyc), longint'(av[d]), longint'(pulse));
                if (pulse) begin
                    check($sformatf("d%0d_result@%0d", d, cyc), longint'(ar[d]),
                          longint'(exp_q[0].res[d]));
                    check($sformatf("d%0d_sat@%0d", d, cyc), longint'(as[d]),
                          longint'(exp_q[0].sat[d]));
                end else begin
                    check($sformatf("d%0d_held@%0d", d, cyc), longint'(ar[d]), held[d]);
                    check($sformatf("d%0d_satidle@%0d", d, cyc), longint'(as[d]), 0);
                end
            end
            if (pulse) begin
                for (int d = 0; d < ND; d++) held[d] = longint'(exp_q[0].res[d]);
                void'(exp_q.pop_front());
            end
            if (av[0]) begin
                e = '0;
                for (int d = 0; d < ND; d++) begin
                    e.res[d] = ar[d];
                    e.sat[d] = as[d];
                end
                e.cyc = 32'(cyc);
                log_q.push_back(e);
            end
        end
        if (rst_n) begin
            for (int d = 0; d < ND; d++) held[d] = 0;
            exp_q.delete();
        end
    end

    initial begin
        int t0;
        fill(0, 0);
        for (int d = 0; d < ND; d++) begin
            acc_m[d] = 0;
            held[d]  = 0;
        end
        rst_n = 1'b1;
        idle(2);
        rst_n  = 1'b0;
        chk_en = 1'b1;
        check("reset_result", longint'(if0.result), 0);
        check("reset_valid", longint'(if0.result_valid), 0);
        check("reset_sat", longint'(if0.sat_flag), 0);

        // Three back-to-back beats; later-beat bias must be ignored.
        fill(3, 7);  log_q.delete();  t0 = cyc;
        drive(1'b1, 0);  drive(1'b1, 77);  drive(1'b1, 77);
        idle(12);
        check("s1_pulses", log_q.size(), 1);
        if (log_q.size() == 1) begin
            check("s1_cycle", longint'(log_q[0].cyc), t0 + 2 + LAT);
            check("s1_u16", longint'(log_q[0].res[0]), 1575);
            check("s1_u16_sat", longint'(log_q[0].sat[0]), 0);
            check("s1_s16", longint'(log_q[0].res[1]), 75);
            check("s1_u8_sat", longint'(log_q[0].res[3]), 255);
            check("s1_u8_satflag", longint'(log_q[0].sat[3]), 1);
            check("s1_u8_trunc", longint'(log_q[0].res[4]), 39);
            check("s1_u8_trunc_sat", longint'(log_q[0].sat[4]), 0);
        end

        // Beats with gaps at relative cycles 0, 4, 5 and bias 10.
        fill(3, 7);  log_q.delete();  t0 = cyc;
        drive(1'b1, 10);  idle(3);  drive(1'b1, 99);  drive(1'b1, 99);
        idle(12);
        check("s2_pulses", log_q.size(), 1);
        if (log_q.size() == 1) begin
            check("s2_cycle", longint'(log_q[0].cyc), t0 + 13);
            check("s2_u16", longint'(log_q[0].res[0]), 1585);
        end

        // Negative products: pic=1, weight=3'b100.
        fill(1, 4);  log_q.delete();
        drive(1'b1, 0);  drive(1'b1, 77);  drive(1'b1, 77);
        idle(12);
        check("s3_pulses", log_q.size(), 1);
        if (log_q.size() == 1) begin
            check("s3_s16", longint'(log_q[0].res[1]), 65236);
            check("s3_relu", longint'(log_q[0].res[2]), 0);
            check("s3_relu_sat", longint'(log_q[0].sat[2]), 0);
            check("s3_u16", longint'(log_q[0].res[0]), 300);
            check("s3_u8_trunc", longint'(log_q[0].res[4]), 44);
        end

        // Reset after two beats (in_valid high during reset), then a fresh window of ones.
        fill(3, 7);  log_q.delete();
        drive(1'b1, 0);  drive(1'b1, 77);
        rst_n = 1'b1;  drive(1'b1, 0);  rst_n = 1'b0;
        fill(1, 1);
        drive(1'b1, 0);  drive(1'b1, 77);  drive(1'b1, 77);
        idle(12);
        check("s5_pulses", log_q.size(), 1);
        if (log_q.size() == 1) check("s5_u16", longint'(log_q[0].res[0]), 75);

        // Six back-to-back beats: two windows at full rate.
        fill(3, 7);  log_q.delete();  t0 = cyc;
        drive(1'b1, 0);  drive(1'b1, 77);  drive(1'b1, 77);
        fill(1, 1);
        drive(1'b1, 0);  drive(1'b1, 77);  drive(1'b1, 77);
        idle(12);
        check("s6_pulses", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("s6_first", longint'(log_q[0].res[0]), 1575);
            check("s6_first_cycle", longint'(log_q[0].cyc), t0 + 2 + LAT);
            check("s6_second", longint'(log_q[1].res[0]), 75);
            check("s6_second_cycle", longint'(log_q[1].cyc), t0 + 5 + LAT);
        end

        // Non-uniform window exercises every adder-tree position.
        for (int i = 0; i < N; i++) begin
            pic_v[i] = i % 4;
            wt_v[i]  = (i * 3) % 8;
        end
        log_q.delete();
        drive(1'b1, 5);  drive(1'b1, 77);  drive(1'b1, 77);
        idle(12);
        check("s7_pulses", log_q.size(), 1);
        if (log_q.size() == 1) check("s7_u16", longint'(log_q[0].res[0]), 401);

        check("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
